// File: rtl/pt2262_tx.sv
// pt2262_tx: PT2262-style tri-state OOK encoder, 1..N frames per request then a done pulse.
// Optional PT2262_TX_ABORT_EN adds an abort input that drops an in-flight request without done.
module pt2262_tx #(
   parameter int N_TRITS   = 12,
   parameter int ALPHA_CYC = 4,
   parameter int REPEAT_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*N_TRITS-1:0]   in_code,
   input  logic [REPEAT_W-1:0]    in_repeats,
`ifdef PT2262_TX_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   q,
   output logic                   busy,
   output logic                   done
);
   localparam int AW = $clog2(ALPHA_CYC + 1);
   localparam int TW = $clog2(N_TRITS + 1);
   typedef enum logic [1:0] {IDLE, TRIT, SYNC} state_t;
   state_t               state, state_n;
   logic [AW-1:0]        ac, ac_n;
   logic [4:0]           sc, sc_n;
   logic [TW-1:0]        ti, ti_n;
   logic [REPEAT_W-1:0]  rep, rep_n;
   logic [2*N_TRITS-1:0] code, code_n;
   logic                 done_n, q_n, alpha_end, abort_go, hb;
   logic [1:0]           pair;
`ifdef PT2262_TX_ABORT_EN
   assign abort_go = abort && state != IDLE;
`else
   assign abort_go = 1'b0;
`endif
   assign alpha_end = ac == AW'(ALPHA_CYC - 1);
   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   always_comb begin
      state_n = state;
      ac_n    = ac;
      sc_n    = sc;
      ti_n    = ti;
      rep_n   = rep;
      code_n  = code;
      done_n  = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            state_n = TRIT;
            ac_n    = '0;
            sc_n    = '0;
            ti_n    = '0;
            rep_n   = in_repeats == '0 ? '0 : in_repeats - 1'b1;
            code_n  = in_code;
         end
         TRIT: begin
            ac_n = alpha_end ? '0 : ac + 1'b1;
            if (alpha_end && sc == 5'd7) begin
               sc_n    = '0;
               ti_n    = ti == TW'(N_TRITS - 1) ? '0 : ti + 1'b1;
               state_n = ti == TW'(N_TRITS - 1) ? SYNC : TRIT;
            end else if (alpha_end)
               sc_n = sc + 1'b1;
         end
         SYNC: begin
            ac_n = alpha_end ? '0 : ac + 1'b1;
            if (alpha_end && sc == 5'd31) begin
               sc_n    = '0;
               state_n = rep == '0 ? IDLE : TRIT;
               done_n  = rep == '0;
               rep_n   = rep == '0 ? rep : rep - 1'b1;
            end else if (alpha_end)
               sc_n = sc + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      if (abort_go) begin
         state_n = IDLE;
         done_n  = 1'b0;
      end
      // q is registered, so the level is derived from where the counters are about to be
      pair = code_n[2*(N_TRITS-1-int'(ti_n)) +: 2];
      hb   = pair == 2'b11 || (pair != 2'b00 && sc_n[2]);
      q_n  = state_n == TRIT ? (hb ? sc_n[1:0] != 2'b11 : sc_n[1:0] == 2'b00)
                             : state_n == SYNC && sc_n == 5'd0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ac    <= '0;
         sc    <= '0;
         ti    <= '0;
         rep   <= '0;
         code  <= '0;
         done  <= 1'b0;
         q     <= 1'b0;
      end else begin
         state <= state_n;
         ac    <= ac_n;
         sc    <= sc_n;
         ti    <= ti_n;
         rep   <= rep_n;
         code  <= code_n;
         done  <= done_n;
         q     <= q_n;
      end
   end
endmodule

// File: tb/tb_pt2262_tx.sv
// tb_pt2262_tx: scoreboard bench for pt2262_tx; expected waveforms are queued at drive time
// and compared per busy cycle, with length/high-count/waveform checked at each done.
module tb_pt2262_tx;
   localparam int ALPHA = 4;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, abort = 1'b0;
   logic [23:0] in_code = '0;
   logic [3:0]  in_repeats = '0;
   logic        in_ready, q, busy, done;
   int checks = 0, errors = 0;
   int m_cyc = 0, m_hi = 0, m_mis = 0, idle_bad = 0, done_seen = 0;
   bit exp_bits[$];
   int exp_len[$];
   int exp_hi[$];

   pt2262_tx #(.N_TRITS(12), .ALPHA_CYC(ALPHA), .REPEAT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_repeats(in_repeats),
`ifdef PT2262_TX_ABORT_EN
      .abort(abort),
`endif
      .q(q), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void push_req(input logic [23:0] c, input logic [3:0] r);
      int nf, len, hi;
      logic [1:0] p;
      bit hb, lv;
      nf = (r == 0) ? 1 : int'(r);
      len = 0;
      hi = 0;
      for (int f = 0; f < nf; f++) begin
         for (int i = 0; i < 12; i++) begin
            p = c[23-2*i -: 2];
            for (int h = 0; h < 2; h++) begin
               hb = (p == 2'b11) ? 1'b1 : (p == 2'b00) ? 1'b0 : (h == 1);
               for (int a = 0; a < 4; a++) begin
                  lv = hb ? (a < 3) : (a == 0);
                  for (int k = 0; k < ALPHA; k++) begin
                     exp_bits.push_back(lv);
                     len++;
                     hi += int'(lv);
                  end
               end
            end
         end
         for (int a = 0; a < 32; a++)
            for (int k = 0; k < ALPHA; k++) begin
               exp_bits.push_back(a == 0);
               len++;
               hi += (a == 0) ? 1 : 0;
            end
      end
      exp_len.push_back(len);
      exp_hi.push_back(hi);
   endfunction

   function automatic void flush();
      exp_bits.delete();
      exp_len.delete();
      exp_hi.delete();
   endfunction

   always @(negedge clk) begin
      if (busy) begin
         if (exp_bits.size() == 0) m_mis++;
         else if (q !== exp_bits.pop_front()) m_mis++;
         m_cyc++;
         if (q) m_hi++;
      end else begin
         if (q !== 1'b0) idle_bad++;
         if (done && !rst) begin
            done_seen++;
            if (exp_len.size() == 0) check("spurious_done", 1, 0);
            else begin
               check("busy_len", m_cyc, exp_len.pop_front());
               check("q_high", m_hi, exp_hi.pop_front());
               check("wave_mismatches", m_mis, 0);
            end
         end
         m_cyc = 0;
         m_hi  = 0;
         m_mis = 0;
      end
   end

   task automatic do_req(input logic [23:0] c, input logic [3:0] r);
      int n = 0;
      @(negedge clk);
      in_code = c;
      in_repeats = r;
      in_valid = 1'b1;
      push_req(c, r);
      while (!in_ready && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("accept_timeout", int'(n >= 4000), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("busy_after_accept", int'(busy), 1);
      check("q_after_accept", int'(q), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", int'(n >= 4000), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int d;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_q", int'(q), 0);
      check("rst_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      do_req(24'hAAAA01, 4'd1);
      wait_idle();
      check("done_cnt_t1", done_seen, 1);
      do_req(24'hAAAA01, 4'd3);
      wait_idle();
      check("done_cnt_t2", done_seen, 2);
      do_req(24'hAAAA01, 4'd0);
      wait_idle();
      check("done_cnt_t3", done_seen, 3);
      do_req(24'h000000, 4'd2);
      do_req(24'hFFFFFF, 4'd1);
      wait_idle();
      check("done_cnt_t4", done_seen, 5);
      do_req(24'h5A5A5A, 4'd1);
      repeat (199) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_q", int'(q), 0);
      check("midrst_in_ready", int'(in_ready), 1);
      check("midrst_busy", int'(busy), 0);
      flush();
      d = done_seen;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (600) @(negedge clk);
      check("midrst_no_done", done_seen, d);
      do_req(24'h1B2C3D, 4'd1);
      wait_idle();
      check("done_cnt_t5", done_seen, d + 1);
`ifdef PT2262_TX_ABORT_EN
      do_req(24'h6E6E6E, 4'd2);
      repeat (98) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_q", int'(q), 0);
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_busy", int'(busy), 0);
      flush();
      d = done_seen;
      repeat (1200) @(negedge clk);
      check("abort_no_done", done_seen, d);
      abort = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_idle_ready", int'(in_ready), 1);
      do_req(24'hC3C3C3, 4'd1);
      abort = 1'b0;
      wait_idle();
      check("abort_at_accept_done", done_seen, d + 1);
`endif
      check("idle_q_nonzero", idle_bad, 0);
      check("leftover_bits", exp_bits.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
